lcd_mode_arbiter: RTL
=====================

// Module: lcd_mode_arbiter
// PURPOSE
//  Parametrised successor to the watch top-level LCD path. Owns the mode register and the HD44780 power-up sequence.
//  Arbitrates N mode channels onto one LCD bus.
//  New vs. previous generation:
//   - configurable channel count and timing
//   - validity mask on selectable modes
//   - programmable parent table for BACK
//   - automatic clear-display on every mode change
//   - per-channel grant so sources restart their line writes.
// PARAMETERS
//  N_MODES   16     number of mode channels; MODE_W = $clog2(N_MODES)
//  PWR_WAIT  70     power-up wait, cycles (state lasts PWR_WAIT+1)
//  CMD_WAIT  30     hold per init command, cycles (+1)
//  CLR_WAIT  2      hold of clear-display command, cycles (+1)
// PORTS
//  CLK_1k      in   1              sole clock; LCD_E = CLK_1k (direct assign)
//  RESET       in   1              asynchronous, active-low
//  SEL_PULSE   in   1              1-cycle pulse: load mode from BUS_INPUT
//  HOME_PULSE  in   1              1-cycle pulse: go to mode 0
//  BACK_PULSE  in   1              1-cycle pulse: go to PARENT[MODE]
//  BUS_INPUT   in   8              requested mode code
//  MODE_VALID  in   N_MODES        bit i=1: mode i implemented
//  PARENT      in   N_MODES*MODE_W flattened parent table, slice i = parent of mode i
//  CH_RS       in   N_MODES        per-channel LCD RS
//  CH_RW       in   N_MODES        per-channel LCD RW
//  CH_DATA     in   N_MODES*8      per-channel LCD data, slice i
//  MODE        out  MODE_W         current mode
//  PROGRAM_EN  out  1              channels may drive the LCD
//  CH_GRANT    out  N_MODES        one-hot of MODE while PROGRAM_EN, else 0
//  LCD_E       out  1              = CLK_1k
//  LCD_RS      out  1              registered
//  LCD_RW      out  1              registered
//  LCD_DATA    out  8              registered
// BEHAVIOUR
//  Reset values: MODE=0, PROGRAM_EN=0, CH_GRANT=0, LCD_RS=1, LCD_RW=1, LCD_DATA=0. Sequencer enters S_DELAY, counter=0.
//  Sequencer states: S_DELAY -> S_FUNC(0x3C) -> S_DISP(0x0C) -> S_ENTRY(0x06) -> S_PROG.
//   - Dwell: S_DELAY lasts PWR_WAIT+1 cycles; each command state lasts CMD_WAIT+1 cycles.
//   - Command states drive RS=0, RW=0; S_DELAY drives RS=1, RW=1, DATA=0.
//  S_PROG: PROGRAM_EN=1. LCD_{RS,RW,DATA} <= CH_*[MODE]; 1-cycle latency from channel input to LCD pins.
//  Mode update (next_mode is registered into MODE on the next edge):
//   - Priority SEL > HOME > BACK.
//   - SEL: BUS_INPUT<N_MODES && MODE_VALID[BUS_INPUT] ? BUS_INPUT : 0.
//   - HOME: 0.
//   - BACK: PARENT[MODE]; if that parent is not valid, 0.
//   - No pulse: hold.
//  Clear on change: a MODE change while in S_PROG enters S_CLEAR (RS=0, RW=0, DATA=0x01) for CLR_WAIT+1 cycles, then returns to S_PROG.
//   - PROGRAM_EN and CH_GRANT are 0 throughout S_CLEAR.
//   - A further mode change during S_CLEAR restarts its counter.
//  Re-selecting the current mode: no clear, no grant glitch.
//  Mode change during init: MODE updates, no S_CLEAR; S_PROG starts with the latest MODE.
//  Counter width must hold max(PWR_WAIT, CMD_WAIT, CLR_WAIT); the counter is cleared on every state entry.
//  RESET low at any time: all outputs return to reset values asynchronously and the full init sequence reruns.
//  Illegal sequencer state: go to S_DELAY, counter=0.
// STRUCTURE
//  Package lcd_watch_pkg:
//   - sequencer state encodings
//   - LCD command constants: FUNC_SET, DISP_ON, ENTRY, CLEAR
//   - MODE_MAIN=0
//  Sub-module lcd_init_seq: init/clear FSM plus dwell counter.
//   - Inputs: clear_req.
//   - Outputs: cmd_rs/rw/data, in_prog.
//  Top level: mode register, validation, parent lookup, registered output mux.
// TESTING
//  1. Release RESET, no pulses -> S_FUNC 0x3C seen at cycle 71, 0x0C at 102, 0x06 at 133; PROGRAM_EN=1 at cycle 164.
//  2. In S_PROG, MODE_VALID[2]=1, BUS=2, SEL pulse:
//     -> MODE=2 next cycle; DATA=0x01 for 3 cycles with GRANT=0;
//     -> then GRANT=0x0004 and LCD_DATA follows CH_DATA[2] one cycle late.
//  3. BUS=9 with MODE_VALID[9]=0, SEL -> MODE=0; BUS=8'hFF -> MODE=0.
//  4. PARENT[3]=2, MODE=3, BACK -> MODE=2.
//     SEL and HOME in the same cycle with BUS=5 valid -> MODE=5.
//  5. Two mode changes 1 cycle apart -> single clear window extended to 4 cycles after the second change.
//     Reselect same mode -> no 0x01 issued.
//  6. RESET low mid-S_CLEAR -> LCD_RS=1, RW=1, DATA=0, MODE=0 immediately; full init reruns.

Source files
------------

// File: rtl/lcd_watch_pkg.sv
// Shared types and constants for the watch LCD path: sequencer states,
// HD44780 command bytes and the home mode index.
package lcd_watch_pkg;

    typedef enum logic [2:0] {
        S_DELAY = 3'd0,
        S_FUNC  = 3'd1,
        S_DISP  = 3'd2,
        S_ENTRY = 3'd3,
        S_PROG  = 3'd4,
        S_CLEAR = 3'd5
    } seq_state_t;

    localparam logic [7:0] FUNC_SET = 8'h3C;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;

    localparam int MODE_MAIN = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_mode_arbiter_if.sv
// Bundle of mode-control inputs, per-channel LCD requests and the arbitrated
// LCD bus. The arbiter is the slave; the sources/controller side is the master.
interface lcd_mode_arbiter_if #(
    parameter int N_MODES = 16,
    parameter int MODE_W  = $clog2(N_MODES)
);

    logic                    SEL_PULSE;
    logic                    HOME_PULSE;
    logic                    BACK_PULSE;
    logic [7:0]              BUS_INPUT;
    logic [N_MODES-1:0]      MODE_VALID;
    logic [N_MODES*MODE_W-1:0] PARENT;
    logic [N_MODES-1:0]      CH_RS;
    logic [N_MODES-1:0]      CH_RW;
    logic [N_MODES*8-1:0]    CH_DATA;

    logic [MODE_W-1:0]       MODE;
    logic                    PROGRAM_EN;
    logic [N_MODES-1:0]      CH_GRANT;
    logic                    LCD_E;
    logic                    LCD_RS;
    logic                    LCD_RW;
    logic [7:0]              LCD_DATA;

    modport master (
        output SEL_PULSE, HOME_PULSE, BACK_PULSE, BUS_INPUT, MODE_VALID, PARENT,
        output CH_RS, CH_RW, CH_DATA,
        input  MODE, PROGRAM_EN, CH_GRANT, LCD_E, LCD_RS, LCD_RW, LCD_DATA
    );

    modport slave (
        input  SEL_PULSE, HOME_PULSE, BACK_PULSE, BUS_INPUT, MODE_VALID, PARENT,
        input  CH_RS, CH_RW, CH_DATA,
        output MODE, PROGRAM_EN, CH_GRANT, LCD_E, LCD_RS, LCD_RW, LCD_DATA
    );

endinterface

// File: rtl/lcd_init_seq.sv
// HD44780 power-up sequencer with a clear-display window on mode changes.
// Command outputs decode the next state so the registered LCD pins line up with state entry.
module lcd_init_seq
    import lcd_watch_pkg::*;
#(
    parameter int PWR_WAIT = 70,
    parameter int CMD_WAIT = 30,
    parameter int CLR_WAIT = 2
) (
    input  logic       CLK_1k,
    input  logic       RESET,
    input  logic       clear_req,
    output logic       cmd_rs,
    output logic       cmd_rw,
    output logic [7:0] cmd_data,
    output logic       prog_next,
    output logic       in_prog
);

    localparam int CNT_W = $clog2(max3(PWR_WAIT, CMD_WAIT, CLR_WAIT) + 1);
    localparam logic [CNT_W-1:0] PWR_END = CNT_W'(PWR_WAIT);
    localparam logic [CNT_W-1:0] CMD_END = CNT_W'(CMD_WAIT);
    localparam logic [CNT_W-1:0] CLR_END = CNT_W'(CLR_WAIT);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;

    always_ff @(posedge CLK_1k or negedge RESET) begin
        if (!RESET) begin
            state <= S_DELAY;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Every state change clears the dwell counter; a fresh mode change in S_CLEAR restarts the window.
    always_comb begin
        state_nxt = state;
        count_nxt = count + 1'b1;
        case (state)
            S_DELAY: if (count >= PWR_END) begin state_nxt = S_FUNC;  count_nxt = '0; end
            S_FUNC:  if (count >= CMD_END) begin state_nxt = S_DISP;  count_nxt = '0; end
            S_DISP:  if (count >= CMD_END) begin state_nxt = S_ENTRY; count_nxt = '0; end
            S_ENTRY: if (count >= CMD_END) begin state_nxt = S_PROG;  count_nxt = '0; end
            S_PROG: begin
                count_nxt = '0;
                if (clear_req) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (clear_req) begin
                    count_nxt = '0;
                end else if (count >= CLR_END) begin
                    state_nxt = S_PROG;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_DELAY;
                count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        cmd_rs   = 1'b1;
        cmd_rw   = 1'b1;
        cmd_data = 8'h00;
        case (state_nxt)
            S_FUNC:  begin cmd_rs = 1'b0; cmd_rw = 1'b0; cmd_data = FUNC_SET; end
            S_DISP:  begin cmd_rs = 1'b0; cmd_rw = 1'b0; cmd_data = DISP_ON;  end
            S_ENTRY: begin cmd_rs = 1'b0; cmd_rw = 1'b0; cmd_data = ENTRY;    end
            S_CLEAR: begin cmd_rs = 1'b0; cmd_rw = 1'b0; cmd_data = CLEAR;    end
            default: ;
        endcase
    end

    assign prog_next = (state_nxt == S_PROG);
    assign in_prog   = (state == S_PROG);

endmodule

// File: rtl/lcd_mode_arbiter.sv
// Mode register with validity/parent navigation, and the registered mux that
// puts either the init sequencer or the selected mode channel onto the LCD bus.
module lcd_mode_arbiter
    import lcd_watch_pkg::*;
#(
    parameter int N_MODES  = 16,
    parameter int PWR_WAIT = 70,
    parameter int CMD_WAIT = 30,
    parameter int CLR_WAIT = 2
) (
    input  logic                 CLK_1k,
    input  logic                 RESET,
    lcd_mode_arbiter_if.slave    bus
);

    localparam int MODE_W = $clog2(N_MODES);
    localparam logic [MODE_W-1:0] MAIN = MODE_W'(MODE_MAIN);

    logic [MODE_W-1:0]  mode, next_mode, sel_mode, back_mode, parent;
    logic [N_MODES-1:0] grant;
    logic               clear_req, prog_next, in_prog;
    logic               cmd_rs, cmd_rw;
    logic [7:0]         cmd_data;
    logic               lcd_rs, lcd_rw;
    logic [7:0]         lcd_data;

    // Unimplemented or out-of-range targets fall back to the main mode.
    always_comb begin
        parent    = bus.PARENT[mode*MODE_W +: MODE_W];
        back_mode = bus.MODE_VALID[parent] ? parent : MAIN;
        sel_mode  = MAIN;
        if ((int'(bus.BUS_INPUT) < N_MODES) && bus.MODE_VALID[bus.BUS_INPUT[MODE_W-1:0]])
            sel_mode = bus.BUS_INPUT[MODE_W-1:0];
        next_mode = mode;
        if (bus.SEL_PULSE)
            next_mode = sel_mode;
        else if (bus.HOME_PULSE)
            next_mode = MAIN;
        else if (bus.BACK_PULSE)
            next_mode = back_mode;
    end

    assign clear_req = (next_mode != mode);

    always_ff @(posedge CLK_1k or negedge RESET) begin
        if (!RESET)
            mode <= MAIN;
        else
            mode <= next_mode;
    end

    lcd_init_seq #(
        .PWR_WAIT (PWR_WAIT),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) u_seq (
        .CLK_1k    (CLK_1k),
        .RESET     (RESET),
        .clear_req (clear_req),
        .cmd_rs    (cmd_rs),
        .cmd_rw    (cmd_rw),
        .cmd_data  (cmd_data),
        .prog_next (prog_next),
        .in_prog   (in_prog)
    );

    // next_mode equals mode whenever S_PROG is entered or held, except when a
    // mode change lands on the last init cycle; then the newest mode is used.
    always_ff @(posedge CLK_1k or negedge RESET) begin
        if (!RESET) begin
            lcd_rs   <= 1'b1;
            lcd_rw   <= 1'b1;
            lcd_data <= 8'h00;
        end else if (prog_next) begin
            lcd_rs   <= bus.CH_RS[next_mode];
            lcd_rw   <= bus.CH_RW[next_mode];
            lcd_data <= bus.CH_DATA[next_mode*8 +: 8];
        end else begin
            lcd_rs   <= cmd_rs;
            lcd_rw   <= cmd_rw;
            lcd_data <= cmd_data;
        end
    end

    always_comb begin
        grant = '0;
        if (in_prog) grant[mode] = 1'b1;
    end

    assign bus.MODE       = mode;
    assign bus.PROGRAM_EN = in_prog;
    assign bus.CH_GRANT   = grant;
    assign bus.LCD_E      = CLK_1k;
    assign bus.LCD_RS     = lcd_rs;
    assign bus.LCD_RW     = lcd_rw;
    assign bus.LCD_DATA   = lcd_data;

endmodule
